seg_bcd_sequencer: RTL and testbench
====================================

SEG_BCD_SEQUENCER -- requirements
Module: seg_bcd_sequencer

Interface
REQ-001 SHALL have parameter IN_W, default 10, meaning input value width in bits (legal 10..16).
REQ-002 SHALL have port Clk  input  1  system clock (27 MHz); all state changes on its rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  binary value offered.
REQ-005 SHALL have port in_value  input  IN_W  unsigned binary value to display.
REQ-006 SHALL have port in_ready  output  1  sequencer can accept a value.
REQ-007 SHALL have port hundreds  output  4  BCD hundreds digit to decoder.
REQ-008 SHALL have port tens  output  4  BCD tens digit to decoder.
REQ-009 SHALL have port ones  output  4  BCD ones digit to decoder.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse: new digits presented.
REQ-011 SHALL have port overflow  output  1  last accepted value exceeded 999.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-013 Handshake SHALL occur on a cycle with in_valid & in_ready; IDLE->SHIFT on the next edge; in_value ignored otherwise.
REQ-014 On accept: value > 999 SHALL be loaded as 999 and overflow set; else value loaded unchanged and overflow cleared.
REQ-015 SHIFT SHALL run sequential double-dabble, one bit per cycle, MSB first, exactly IN_W cycles: per cycle, add 3 to each 4-bit BCD digit >= 5, then shift left 1 bit into a 12-bit BCD register.
REQ-016 After the IN_W-th shift, FSM SHALL go SHIFT->DONE; in DONE hundreds/tens/ones SHALL be registered from the BCD register and out_valid pulsed for exactly one cycle; DONE->IDLE on the next edge.
REQ-017 Latency SHALL be IN_W+2 cycles from handshake edge to out_valid high (12 cycles at IN_W=10); throughput one value per IN_W+2 cycles.
REQ-018 hundreds/tens/ones/overflow SHALL hold their last values between conversions (display never shows intermediate shift contents).
REQ-019 in_valid high during SHIFT/DONE SHALL be ignored (no queueing); requester must hold in_valid until in_ready.
REQ-020 in_value = 0 SHALL produce digits 0,0,0 (ones always shows a numeral).
REQ-021 in_value = 999 and 1000 SHALL both produce 9,9,9; overflow 0 and 1 respectively.

Reset
REQ-022 Rst_n low SHALL immediately force FSM IDLE, in_ready 1, out_valid 0, overflow 0, BCD register 0, hundreds/tens/ones per REQ-024/025.
REQ-023 Reset asserted mid-SHIFT SHALL abort the conversion with no out_valid pulse; first accept after release starts fresh.

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined: in DONE, a zero hundreds digit SHALL output 4'hF; a zero tens digit SHALL output 4'hF when hundreds is also zero; ones never blanked; reset values hundreds=F, tens=F, ones=0.
REQ-025 Without LEADING_ZERO_BLANK_EN: digits SHALL be output unmodified; reset values 0,0,0.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, BCD digit typedef (4 bits), MAX_VAL = 999, BLANK_CODE = 4'hF.
REQ-027 One sub-module bcd_add3 (4-bit in, 4-bit out, +3 if >= 5) SHALL be instantiated three times for the correction step.

Verification
REQ-028 Reset, then in_value=10'd123 with in_valid=1 -> in_ready drops next cycle, out_valid high 12 cycles after handshake, digits 1,2,3, overflow 0.
REQ-029 in_value=1023 -> digits 9,9,9, overflow 1; then in_value=5 -> overflow 0, digits 0,0,5 (blank build: F,F,5).
REQ-030 in_value=0 then in_value=40 -> blank build F,F,0 then F,4,0; non-blank build 0,0,0 then 0,4,0.
REQ-031 Hold in_valid high with new in_value=777 during an active conversion of 321 -> 321 completes unchanged, 777 accepted on the first in_ready cycle, two out_valid pulses total.
REQ-032 Assert Rst_n low 5 cycles into SHIFT of 456 -> no out_valid, outputs at reset values, in_ready 1 asynchronously; next value 789 converts correctly.
REQ-033 Exhaustive sweep 0..999 back-to-back -> every out_valid carries the correct BCD of its value, spacing exactly 12 cycles.

Source files
------------

// File: rtl/seg_bcd_sequencer_pkg.sv
// Shared types and constants for the binary-to-BCD display sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_bcd_sequencer_pkg;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // One BCD digit as presented to the 7-segment decoder
    typedef logic [3:0] bcd_digit_t;

    // Largest value the three-digit display can show; larger inputs saturate
    localparam int MAX_VAL = 999;

    // Decoder code that lights no segments
    localparam bcd_digit_t BLANK_CODE = 4'hF;

    // Shift counter width, enough for IN_W up to 16
    localparam int CNT_W = 5;

endpackage

// File: rtl/seg_bcd_sequencer_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: digit_i - digit before correction; digit_o - corrected digit.
module bcd_add3
    import seg_bcd_sequencer_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/seg_bcd_sequencer.sv
// Converts an accepted binary value (saturated at 999) into three BCD digits by serial double-dabble.
// Latency: IN_W+2 cycles from handshake to out_valid; one value per IN_W+2 cycles.
// Backpressure: in_ready only in IDLE; in_valid outside IDLE is ignored, requester must hold it.
// Ports: Clk/Rst_n (async active-low), in_valid/in_value/in_ready (input handshake),
//        hundreds/tens/ones (held digits), out_valid (1-cycle pulse), overflow (last value > 999).
// Option: LEADING_ZERO_BLANK_EN replaces leading zero hundreds/tens with BLANK_CODE.
module seg_bcd_sequencer
    import seg_bcd_sequencer_pkg::*;
#(
    parameter int IN_W = 10
)
(
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_value,
    output logic            in_ready,
    output logic [3:0]      hundreds,
    output logic [3:0]      tens,
    output logic [3:0]      ones,
    output logic            out_valid,
    output logic            overflow
);

    localparam logic [IN_W-1:0]  MAX_IN   = IN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bcd_digit_t RST_HT = BLANK_CODE;
`else
    localparam bcd_digit_t RST_HT = 4'h0;
`endif

    state_e           state_q, state_d;
    logic             accept, shifting, done_st, last_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  sreg_q, sreg_d;
    logic [11:0]      bcd_q, bcd_d, bcd_corr;
    bcd_digit_t       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic             ovf_q, ovf_d;
    logic             ovld_q;

    // Correction step applied to all three digits before every shift
    bcd_add3 u_add3_ones (.digit_i(bcd_q[3:0]),  .digit_o(bcd_corr[3:0]));
    bcd_add3 u_add3_tens (.digit_i(bcd_q[7:4]),  .digit_o(bcd_corr[7:4]));
    bcd_add3 u_add3_hund (.digit_i(bcd_q[11:8]), .digit_o(bcd_corr[11:8]));

    // FSM: state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs / datapath controls
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        accept     = in_valid && (state_q == ST_IDLE);
        shifting   = (state_q == ST_SHIFT);
        done_st    = (state_q == ST_DONE);
        last_shift = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    end

    // Datapath next state
    always_comb begin
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        hund_d = hund_q;
        tens_d = tens_q;
        ones_d = ones_q;
        if (accept) begin
            cnt_d = '0;
            bcd_d = '0;
            if (in_value > MAX_IN) begin
                sreg_d = MAX_IN;
                ovf_d  = 1'b1;
            end else begin
                sreg_d = in_value;
                ovf_d  = 1'b0;
            end
        end
        if (shifting) begin
            cnt_d  = cnt_q + CNT_W'(1);
            sreg_d = {sreg_q[IN_W-2:0], 1'b0};
            // Hundreds never exceeds 9, so the carry out of the corrected
            // hundreds digit is always zero and is dropped by the truncation.
            bcd_d  = 12'({bcd_corr, sreg_q[IN_W-1]});
        end
        // Display registers only load here, so shift contents never reach them
        if (done_st) begin
            hund_d = bcd_q[11:8];
            tens_d = bcd_q[7:4];
            ones_d = bcd_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
            if (bcd_q[11:8] == 4'd0) begin
                hund_d = BLANK_CODE;
                if (bcd_q[7:4] == 4'd0) begin
                    tens_d = BLANK_CODE;
                end
            end
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q  <= '0;
            sreg_q <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            hund_q <= RST_HT;
            tens_q <= RST_HT;
            ones_q <= 4'h0;
            ovld_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sreg_q <= sreg_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
            hund_q <= hund_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            ovld_q <= done_st;
        end
    end

    assign hundreds  = hund_q;
    assign tens      = tens_q;
    assign ones      = ones_q;
    assign overflow  = ovf_q;
    assign out_valid = ovld_q;

endmodule

// File: tb/tb_seg_bcd_sequencer.sv
// Scoreboard bench for seg_bcd_sequencer: stimulus pushes expected digits, monitor pops on out_valid.
// Latency: checks 12 cycles handshake-to-out_valid and 12-cycle spacing in back-to-back sweep.
// Backpressure: stimulus holds in_valid until in_ready.
module tb_seg_bcd_sequencer;

    localparam int IN_W = 10;
`ifdef LEADING_ZERO_BLANK_EN
    localparam int BLANK = 1;
`else
    localparam int BLANK = 0;
`endif
    localparam int RST_HT = (BLANK != 0) ? 15 : 0;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [IN_W-1:0] in_value = '0;
    logic            in_ready;
    logic [3:0]      hundreds, tens, ones;
    logic            out_valid;
    logic            overflow;

    seg_bcd_sequencer #(.IN_W(IN_W)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .in_valid (in_valid),
        .in_value (in_value),
        .in_ready (in_ready),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .out_valid(out_valid),
        .overflow (overflow)
    );

    typedef struct {
        int     val;
        int     h;
        int     t;
        int     o;
        int     ovf;
        longint hs;
    } exp_t;

    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;
    int     pulses = 0;
    longint cyc = 0;
    int     last_h = 0, last_t = 0, last_o = 0;
    bit     sweep_on = 1'b0;
    bit     sweep_first = 1'b1;
    longint prev_pulse = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Leading-zero blanking as seen on the decoder inputs
    task automatic blank_fix(inout int h, inout int t);
        if (BLANK != 0 && h == 0) begin
            h = 15;
            if (t == 0) t = 15;
        end
    endtask

    // Offer a value and hold it until accepted; push the expected result at the handshake
    task automatic send(input int val, input int h, input int t, input int o, input int ovf);
        int   n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_value = IN_W'(val);
        while (!in_ready && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk($sformatf("handshake[%0d]", val), int'(in_ready), 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        blank_fix(h, t);
        e.val = val; e.h = h; e.t = t; e.o = o; e.ovf = ovf; e.hs = cyc;
        sb_q.push_back(e);
        @(negedge Clk);
        in_valid = 1'b0;
        chk($sformatf("ready_drop[%0d]", val), int'(in_ready), 0);
    endtask

    // Arithmetic reference for the sweep
    task automatic send_model(input int v);
        int c;
        c = (v > 999) ? 999 : v;
        send(v, c / 100, (c / 10) % 10, c % 10, (v > 999) ? 1 : 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("drain_queue_empty", sb_q.size(), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready),  1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_overflow"},  int'(overflow),  0);
        chk({tag, "_hundreds"},  int'(hundreds),  RST_HT);
        chk({tag, "_tens"},      int'(tens),      RST_HT);
        chk({tag, "_ones"},      int'(ones),      0);
    endtask

    // Monitor
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst_n) begin
            last_h = RST_HT;
            last_t = RST_HT;
            last_o = 0;
        end else if (out_valid) begin
            pulses++;
            if (sweep_on) begin
                if (!sweep_first) chk("sweep_spacing", int'(cyc - prev_pulse), 12);
                sweep_first = 1'b0;
                prev_pulse  = cyc;
            end
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("hundreds[%0d]", e.val), int'(hundreds), e.h);
                chk($sformatf("tens[%0d]", e.val),     int'(tens),     e.t);
                chk($sformatf("ones[%0d]", e.val),     int'(ones),     e.o);
                chk($sformatf("overflow[%0d]", e.val), int'(overflow), e.ovf);
                chk($sformatf("latency[%0d]", e.val),  int'(cyc - e.hs), 12);
            end
            last_h = int'(hundreds);
            last_t = int'(tens);
            last_o = int'(ones);
        end else begin
            chk("digits_hold", int'({hundreds, tens, ones}), last_h * 256 + last_t * 16 + last_o);
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got running, expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int p0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Basic conversion, saturation, small value after overflow
        send(123, 1, 2, 3, 0);
        drain();
        send(1023, 9, 9, 9, 1);
        send(5, 0, 0, 5, 0);
        drain();

        // Zero, tens-only, and the 999/1000 boundary
        send(0, 0, 0, 0, 0);
        send(40, 0, 4, 0, 0);
        send(999, 9, 9, 9, 0);
        send(1000, 9, 9, 9, 1);
        drain();

        // New value held during a conversion is taken only once ready returns
        p0 = pulses;
        send(321, 3, 2, 1, 0);
        send(777, 7, 7, 7, 0);
        drain();
        chk("two_pulses", pulses - p0, 2);

        // Reset mid-SHIFT aborts the conversion
        send(456, 4, 5, 6, 0);
        repeat (5) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb_q.delete();
        p0 = pulses;
        repeat (2) @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);
        chk("no_pulse_after_reset", pulses - p0, 0);
        send(789, 7, 8, 9, 0);
        drain();

        // Back-to-back sweep
        p0 = pulses;
        sweep_on = 1'b1;
        sweep_first = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            send_model(v);
        end
        drain();
        sweep_on = 1'b0;
        chk("sweep_pulses", pulses - p0, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
